// File: rtl/ahb_seven_segment_mux.sv
// AHB-Lite slave driving a multiplexed common-cathode seven-segment display.
// Handles scanning, leading-zero suppression, per-digit blink and PWM dimming.
module ahb_seven_segment_mux #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SLOT_CYCLES  = 1000,
    parameter int unsigned BLINK_FRAMES = 64,
    parameter int unsigned PWM_BITS     = 4
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic                  HREADY,
    input  logic                  HWRITE,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic [31:0]           HWDATA,
    output logic [31:0]           HRDATA,
    output logic                  HREADYOUT,
    output logic                  SegA,
    output logic                  SegB,
    output logic                  SegC,
    output logic                  SegD,
    output logic                  SegE,
    output logic                  SegF,
    output logic                  SegG,
    output logic                  DP,
    output logic [NUM_DIGITS-1:0] nDigit
);

    localparam int unsigned DIG_W  = $clog2(NUM_DIGITS);
    localparam int unsigned PRE_W  = $clog2(SLOT_CYCLES);
    localparam int unsigned FRM_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int unsigned DATA_W = 4 * NUM_DIGITS;

    localparam logic [2:0] OFF_DATA   = 3'd0;
    localparam logic [2:0] OFF_DPEN   = 3'd1;
    localparam logic [2:0] OFF_CTRL   = 3'd2;
    localparam logic [2:0] OFF_BMASK  = 3'd3;
    localparam logic [2:0] OFF_STATUS = 3'd4;

    // Bus data-phase tracking
    logic       accept;
    logic       dp_valid_q;
    logic       dp_write_q;
    logic [2:0] dp_off_q;
    logic       wr_en;
    logic       rd_en;

    // Software-visible registers
    logic [DATA_W-1:0]     data_q;
    logic [NUM_DIGITS-1:0] dpen_q;
    logic                  en_q;
    logic                  lzs_q;
    logic                  blink_q;
    logic [PWM_BITS-1:0]   bright_q;
    logic [NUM_DIGITS-1:0] bmask_q;

    // Scan, blink and PWM counters
    logic [PRE_W-1:0]    presc_q;
    logic [DIG_W-1:0]    digit_q;
    logic [FRM_W-1:0]    frame_q;
    logic                phase_q;
    logic [PWM_BITS-1:0] pwm_q;
    logic                slot_end;
    logic                frame_end;

    // Display datapath
    logic [3:0]            nibble [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] lz_blank;
    logic                  blank;
    logic [6:0]            seg_d;
    logic [6:0]            seg_q;
    logic                  dp_d;
    logic                  dp_q;
    logic [NUM_DIGITS-1:0] ndigit_d;
    logic [NUM_DIGITS-1:0] ndigit_q;

    logic unused_bits;
    assign unused_bits = ^{HADDR[31:5], HADDR[1:0], HTRANS[0], HSIZE, HWDATA};

    assign HREADYOUT = 1'b1;

    // ------------------------------------------------------------------
    // AHB-Lite slave
    // ------------------------------------------------------------------
    assign accept = HSEL & HREADY & HTRANS[1];
    assign wr_en  = dp_valid_q & dp_write_q;
    assign rd_en  = dp_valid_q & ~dp_write_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_off_q   <= 3'd0;
        end else if (HREADY) begin
            dp_valid_q <= accept;
            dp_write_q <= HWRITE;
            dp_off_q   <= HADDR[4:2];
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            data_q   <= '0;
            dpen_q   <= '0;
            en_q     <= 1'b0;
            lzs_q    <= 1'b0;
            blink_q  <= 1'b0;
            bright_q <= '0;
            bmask_q  <= '0;
        end else if (wr_en) begin
            case (dp_off_q)
                OFF_DATA:  data_q <= HWDATA[DATA_W-1:0];
                OFF_DPEN:  dpen_q <= HWDATA[NUM_DIGITS-1:0];
                OFF_CTRL: begin
                    en_q     <= HWDATA[0];
                    lzs_q    <= HWDATA[1];
                    blink_q  <= HWDATA[2];
                    bright_q <= HWDATA[8 +: PWM_BITS];
                end
                OFF_BMASK: bmask_q <= HWDATA[NUM_DIGITS-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        HRDATA = '0;
        if (rd_en) begin
            case (dp_off_q)
                OFF_DATA:  HRDATA[DATA_W-1:0]     = data_q;
                OFF_DPEN:  HRDATA[NUM_DIGITS-1:0] = dpen_q;
                OFF_CTRL: begin
                    HRDATA[0]             = en_q;
                    HRDATA[1]             = lzs_q;
                    HRDATA[2]             = blink_q;
                    HRDATA[8 +: PWM_BITS] = bright_q;
                end
                OFF_BMASK: HRDATA[NUM_DIGITS-1:0] = bmask_q;
                OFF_STATUS: begin
                    HRDATA[DIG_W-1:0] = digit_q;
                    HRDATA[8]         = phase_q;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Scan, blink and PWM counters (free-running, independent of EN)
    // ------------------------------------------------------------------
    assign slot_end  = (presc_q == PRE_W'(SLOT_CYCLES - 1));
    assign frame_end = slot_end & (digit_q == DIG_W'(NUM_DIGITS - 1));

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            presc_q <= '0;
            digit_q <= '0;
            frame_q <= '0;
            phase_q <= 1'b0;
            pwm_q   <= '0;
        end else begin
            pwm_q   <= pwm_q + PWM_BITS'(1);
            presc_q <= slot_end ? '0 : presc_q + PRE_W'(1);
            if (slot_end) begin
                digit_q <= frame_end ? '0 : digit_q + DIG_W'(1);
            end
            if (frame_end) begin
                if (frame_q == FRM_W'(BLINK_FRAMES - 1)) begin
                    frame_q <= '0;
                    phase_q <= ~phase_q;
                end else begin
                    frame_q <= frame_q + FRM_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Display datapath
    // ------------------------------------------------------------------
    function automatic logic [6:0] font(input logic [3:0] v);
        // Bit order {a,b,c,d,e,f,g}
        case (v)
            4'h0: font = 7'b1111110;
            4'h1: font = 7'b0110000;
            4'h2: font = 7'b1101101;
            4'h3: font = 7'b1111001;
            4'h4: font = 7'b0110011;
            4'h5: font = 7'b1011011;
            4'h6: font = 7'b1011111;
            4'h7: font = 7'b1110000;
            4'h8: font = 7'b1111111;
            4'h9: font = 7'b1111011;
            4'hA: font = 7'b1110111;
            4'hB: font = 7'b0011111;
            4'hC: font = 7'b1001110;
            4'hD: font = 7'b0111101;
            4'hE: font = 7'b1001111;
            default: font = 7'b1000111;
        endcase
    endfunction

    // A DP-enabled digit counts as significant, so suppression stops at it and
    // the zeros below it stay visible (e.g. " 0.05").
    always_comb begin : lzs_calc
        logic zero_above;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nibble[i]   = data_q[4*i +: 4];
            zero_above  = zero_above & (nibble[i] == 4'h0) & ~dpen_q[i];
            lz_blank[i] = zero_above & (i != 0);
        end
    end

    always_comb begin
        blank = ~en_q
              | (lzs_q & lz_blank[digit_q])
              | (blink_q & phase_q & bmask_q[digit_q])
              | (pwm_q > bright_q);
        seg_d = blank ? 7'b0 : font(nibble[digit_q]);
        dp_d  = ~blank & dpen_q[digit_q];
        for (int i = 0; i < NUM_DIGITS; i++) begin
            ndigit_d[i] = blank | (DIG_W'(i) != digit_q);
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            seg_q    <= 7'b0;
            dp_q     <= 1'b0;
            ndigit_q <= '1;
        end else begin
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            ndigit_q <= ndigit_d;
        end
    end

    assign {SegA, SegB, SegC, SegD, SegE, SegF, SegG} = seg_q;
    assign DP     = dp_q;
    assign nDigit = ndigit_q;

endmodule
